// File: rtl/qed_ctrl_pkg.sv
// Shared types and constants for the QED duplication sequencer.
package qed_ctrl_pkg;

  localparam int unsigned QED_DEPTH_DEF = 8;
  localparam logic [15:0] WD_LIMIT      = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ORIG  = 3'd1,
    DUP   = 3'd2,
    DRAIN = 3'd3,
    CHECK = 3'd4
  } qed_state_e;

endpackage

// File: rtl/qed_cnt_pair.sv
// Issue/commit counter pair; issue saturates at iss_lim, commit saturates at the issue count.
module qed_cnt_pair #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             iss_inc,
  input  logic [CNT_W-1:0] iss_lim,
  input  logic             cmt_inc,
  output logic [CNT_W-1:0] iss,
  output logic [CNT_W-1:0] iss_nxt_c,
  output logic [CNT_W-1:0] cmt_nxt_c,
  output logic             ovf_c
);

  logic [CNT_W-1:0] cmt;

  // A same-cycle issue makes a same-cycle commit of that instruction legal.
  always_comb begin
    iss_nxt_c = iss;
    cmt_nxt_c = cmt;
    ovf_c     = 1'b0;
    if (iss_inc && (iss < iss_lim)) iss_nxt_c = iss + CNT_W'(1);
    if (cmt_inc) begin
      if (cmt >= iss_nxt_c) ovf_c = 1'b1;
      else                  cmt_nxt_c = cmt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      iss <= '0;
      cmt <= '0;
    end else begin
      iss <= iss_nxt_c;
      cmt <= cmt_nxt_c;
    end
  end

endmodule

// File: rtl/qed_dup_controller.sv
// QED duplication sequencer: issues a window of originals, replays duplicates, drains, checks.
// Optional idle watchdog on qed_err when QED_WATCHDOG_EN is defined.
module qed_dup_controller
  import qed_ctrl_pkg::*;
#(
  parameter int unsigned QED_DEPTH = QED_DEPTH_DEF,
  parameter int unsigned CNT_W     = $clog2(QED_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             stall_IF,
  input  logic             fetch_fire,
  input  logic             qic_vld,
  input  logic             dup_req,
  input  logic             commit_vld,
  input  logic             commit_is_dup,
  output logic             exec_dup,
  output logic             qed_ena,
  output logic             fetch_hold,
  output logic             qed_check,
  output logic             qed_err,
  output logic [CNT_W-1:0] orig_cnt
);

  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(QED_DEPTH);

  qed_state_e       state;
  logic [CNT_W-1:0] orig_iss_nxt_c, orig_cmt_nxt_c;
  logic [CNT_W-1:0] dup_iss, dup_iss_nxt_c, dup_cmt_nxt_c;
  logic             orig_ovf_c, dup_ovf_c;
  logic             busy_c, clr_c, full_c, switch_c, err_c, wd_c;

  assign busy_c   = (state == ORIG) || (state == DUP) || (state == DRAIN);
  assign clr_c    = (state == IDLE) || (state == CHECK) || !ena;
  assign full_c   = (orig_iss_nxt_c == DEPTH);
  assign switch_c = (dup_req || full_c) && (orig_iss_nxt_c != '0) && !stall_IF;
  assign err_c    = orig_ovf_c || dup_ovf_c || wd_c ||
                    ((state == DUP) && fetch_fire && !qic_vld);

  qed_cnt_pair #(.CNT_W(CNT_W)) u_orig (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr_c),
    .iss_inc   ((state == ORIG) && fetch_fire),
    .iss_lim   (DEPTH),
    .cmt_inc   (busy_c && commit_vld && !commit_is_dup),
    .iss       (orig_cnt),
    .iss_nxt_c (orig_iss_nxt_c),
    .cmt_nxt_c (orig_cmt_nxt_c),
    .ovf_c     (orig_ovf_c)
  );

  // Duplicates can never outnumber the originals they replay.
  qed_cnt_pair #(.CNT_W(CNT_W)) u_dup (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr_c),
    .iss_inc   ((state == DUP) && fetch_fire && qic_vld),
    .iss_lim   (orig_cnt),
    .cmt_inc   (busy_c && commit_vld && commit_is_dup),
    .iss       (dup_iss),
    .iss_nxt_c (dup_iss_nxt_c),
    .cmt_nxt_c (dup_cmt_nxt_c),
    .ovf_c     (dup_ovf_c)
  );

`ifdef QED_WATCHDOG_EN
  logic [15:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (!rst || !((state == DUP) || (state == DRAIN)) || fetch_fire || commit_vld)
      idle_cnt <= '0;
    else if (idle_cnt != WD_LIMIT)
      idle_cnt <= idle_cnt + 16'd1;
  end

  assign wd_c = (idle_cnt == WD_LIMIT);
`else
  assign wd_c = 1'b0;
`endif

  // Sequencer with registered outputs; exec_dup only moves while fetch is not stalled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      exec_dup   <= 1'b0;
      qed_ena    <= 1'b0;
      fetch_hold <= 1'b0;
      qed_check  <= 1'b0;
      qed_err    <= 1'b0;
    end else if ((state != IDLE) && !ena) begin
      state      <= IDLE;
      exec_dup   <= 1'b0;
      qed_ena    <= 1'b0;
      fetch_hold <= 1'b0;
      qed_check  <= 1'b0;
    end else begin
      qed_check <= 1'b0;
      if (err_c) qed_err <= 1'b1;
      case (state)
        IDLE: begin
          if (ena) begin
            state   <= ORIG;
            qed_ena <= 1'b1;
          end
        end
        ORIG: begin
          if (switch_c) begin
            state      <= DUP;
            exec_dup   <= 1'b1;
            fetch_hold <= 1'b0;
          end else begin
            fetch_hold <= full_c;
          end
        end
        DUP: begin
          if ((dup_iss_nxt_c == orig_cnt) && !stall_IF) begin
            state      <= DRAIN;
            exec_dup   <= 1'b0;
            fetch_hold <= 1'b1;
          end
        end
        DRAIN: begin
          if ((orig_cmt_nxt_c == orig_cnt) && (dup_cmt_nxt_c == dup_iss)) begin
            state     <= CHECK;
            qed_check <= 1'b1;
          end
        end
        CHECK: begin
          state      <= ORIG;
          fetch_hold <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          exec_dup   <= 1'b0;
          qed_ena    <= 1'b0;
          fetch_hold <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qed_dup_controller.sv
// Bench for qed_dup_controller at QED_DEPTH=4: vector table, directed corners, random vs model.
module tb_qed_dup_controller;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst, ena, stall_IF, fetch_fire, qic_vld, dup_req, commit_vld, commit_is_dup;
  logic       exec_dup, qed_ena, fetch_hold, qed_check, qed_err;
  logic [2:0] orig_cnt;

  always #5 clk = ~clk;

  qed_dup_controller #(.QED_DEPTH(D)) dut (
    .clk           (clk),
    .rst           (rst),
    .ena           (ena),
    .stall_IF      (stall_IF),
    .fetch_fire    (fetch_fire),
    .qic_vld       (qic_vld),
    .dup_req       (dup_req),
    .commit_vld    (commit_vld),
    .commit_is_dup (commit_is_dup),
    .exec_dup      (exec_dup),
    .qed_ena       (qed_ena),
    .fetch_hold    (fetch_hold),
    .qed_check     (qed_check),
    .qed_err       (qed_err),
    .orig_cnt      (orig_cnt)
  );

  // Input bits: {rst, ena, stall, fire, qic_vld, dup_req, commit, commit_is_dup}
  // Output bits: {exec_dup, qed_ena, fetch_hold, qed_check, qed_err}
  typedef struct {
    logic [7:0] in;
    logic [4:0] out;
    int         ocnt;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: window phase plus four plain integer tallies.
  localparam int PH_IDLE = 0, PH_ORIG = 1, PH_DUP = 2, PH_DRAIN = 3, PH_CHECK = 4;
  int phase = PH_IDLE;
  int oi = 0, di = 0, oc = 0, dc = 0;
  bit m_exec = 0, m_qena = 0, m_hold = 0, m_chk = 0, m_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input logic [7:0] in);
    bit r, e, s, f, q, dq, c, k;
    int noi, ndi, noc, ndc;
    {r, e, s, f, q, dq, c, k} = in;
    if (!r) begin
      phase = PH_IDLE; oi = 0; di = 0; oc = 0; dc = 0;
      m_exec = 0; m_qena = 0; m_hold = 0; m_chk = 0; m_err = 0;
    end else if (phase != PH_IDLE && !e) begin
      phase = PH_IDLE; oi = 0; di = 0; oc = 0; dc = 0;
      m_exec = 0; m_qena = 0; m_hold = 0; m_chk = 0;
    end else begin
      noi = oi; ndi = di; noc = oc; ndc = dc;
      m_chk = 0;
      if (phase == PH_ORIG && f && oi < D) noi = oi + 1;
      if (phase == PH_DUP && f) begin
        if (!q) m_err = 1;
        else if (di < oi) ndi = di + 1;
      end
      if (c && (phase == PH_ORIG || phase == PH_DUP || phase == PH_DRAIN)) begin
        if (k) begin
          if (dc < ndi) ndc = dc + 1; else m_err = 1;
        end else begin
          if (oc < noi) noc = oc + 1; else m_err = 1;
        end
      end
      case (phase)
        PH_IDLE: if (e) begin phase = PH_ORIG; m_qena = 1; end
        PH_ORIG: begin
          if ((dq || noi == D) && noi > 0 && !s) begin
            phase = PH_DUP; m_exec = 1; m_hold = 0;
          end else m_hold = (noi == D);
        end
        PH_DUP: if (ndi == oi && !s) begin phase = PH_DRAIN; m_exec = 0; m_hold = 1; end
        PH_DRAIN: if (noc == oi && ndc == di) begin phase = PH_CHECK; m_chk = 1; end
        default: begin
          phase = PH_ORIG; m_hold = 0;
          noi = 0; ndi = 0; noc = 0; ndc = 0;
        end
      endcase
      oi = noi; di = ndi; oc = noc; dc = ndc;
    end
  endtask

  // Drive one cycle, advance the model, and compare every output #1 after the edge.
  task automatic step(input logic [7:0] in);
    {rst, ena, stall_IF, fetch_fire, qic_vld, dup_req, commit_vld, commit_is_dup} = in;
    @(posedge clk);
    model_step(in);
    cyc++;
    #1;
    check("exec_dup",   int'(exec_dup),   int'(m_exec));
    check("qed_ena",    int'(qed_ena),    int'(m_qena));
    check("fetch_hold", int'(fetch_hold), int'(m_hold));
    check("qed_check",  int'(qed_check),  int'(m_chk));
    check("qed_err",    int'(qed_err),    int'(m_err));
    check("orig_cnt",   int'(orig_cnt),   oi);
  endtask

  function automatic vec_t v(input logic [7:0] in, input logic [4:0] out, input int ocnt);
    vec_t t;
    t.in = in; t.out = out; t.ocnt = ocnt;
    return t;
  endfunction

  vec_t tbl[15];

  initial begin
    logic [7:0] rin;
    // Fill a window, replay with overlapping commits, drain, check.
    tbl[0]  = v(8'b0000_0000, 5'b00000, 0);
    tbl[1]  = v(8'b1100_0000, 5'b01000, 0);
    tbl[2]  = v(8'b1101_0000, 5'b01000, 1);
    tbl[3]  = v(8'b1101_0000, 5'b01000, 2);
    tbl[4]  = v(8'b1101_0000, 5'b01000, 3);
    tbl[5]  = v(8'b1101_0000, 5'b11000, 4);
    tbl[6]  = v(8'b1101_1010, 5'b11000, 4);
    tbl[7]  = v(8'b1101_1010, 5'b11000, 4);
    tbl[8]  = v(8'b1101_1010, 5'b11000, 4);
    tbl[9]  = v(8'b1101_1010, 5'b01100, 4);
    tbl[10] = v(8'b1100_0011, 5'b01100, 4);
    tbl[11] = v(8'b1100_0011, 5'b01100, 4);
    tbl[12] = v(8'b1100_0011, 5'b01100, 4);
    tbl[13] = v(8'b1100_0011, 5'b01110, 4);
    tbl[14] = v(8'b1100_0000, 5'b01000, 0);

    {rst, ena, stall_IF, fetch_fire, qic_vld, dup_req, commit_vld, commit_is_dup} = '0;
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].in);
      check($sformatf("tbl%0d_outs", i),
            int'({exec_dup, qed_ena, fetch_hold, qed_check, qed_err}), int'(tbl[i].out));
      check($sformatf("tbl%0d_ocnt", i), int'(orig_cnt), tbl[i].ocnt);
    end

    // Early switch after two originals; drain after exactly two duplicates.
    step(8'b1101_0000);
    step(8'b1101_0000);
    step(8'b1100_0100);
    check("early_exec", int'(exec_dup), 1);
    check("early_ocnt", int'(orig_cnt), 2);
    step(8'b1101_1000);
    check("early_dup1_hold", int'(fetch_hold), 0);
    step(8'b1101_1000);
    check("early_drain_hold", int'(fetch_hold), 1);
    check("early_drain_exec", int'(exec_dup), 0);
    step(8'b1100_0010);
    step(8'b1100_0010);
    step(8'b1100_0011);
    check("early_no_chk", int'(qed_check), 0);
    step(8'b1100_0011);
    check("early_chk", int'(qed_check), 1);
    step(8'b1100_0000);
    check("early_chk_pulse", int'(qed_check), 0);
    check("early_ocnt_clr", int'(orig_cnt), 0);

    // Full window whose switch is blocked by stall_IF.
    step(8'b1101_0000);
    step(8'b1101_0000);
    step(8'b1101_0000);
    step(8'b1111_0000);
    check("stall_hold0", int'(fetch_hold), 1);
    for (int i = 0; i < 3; i++) begin
      step(8'b1110_0000);
      check("stall_hold", int'(fetch_hold), 1);
      check("stall_exec", int'(exec_dup), 0);
    end
    step(8'b1100_0000);
    check("stall_release_exec", int'(exec_dup), 1);
    for (int i = 0; i < 4; i++) step(8'b1101_1000);
    check("stall_drain", int'(fetch_hold), 1);
    for (int i = 0; i < 4; i++) step(8'b1100_0011);
    check("no_err_yet", int'(qed_err), 0);
    step(8'b1100_0011);
    check("dup_cmt_ovf", int'(qed_err), 1);
    for (int i = 0; i < 4; i++) step(8'b1100_0010);
    check("ovf_window_chk", int'(qed_check), 1);
    step(8'b1100_0000);

    // Reset clears the sticky error; missing duplicate sets it again.
    step(8'b0000_0000);
    check("rst_err_clr", int'(qed_err), 0);
    step(8'b1100_0000);
    step(8'b1101_0000);
    step(8'b1100_0100);
    step(8'b1101_0000);
    check("qic_err", int'(qed_err), 1);
    step(8'b1100_0000);
    check("qic_err_sticky", int'(qed_err), 1);
    step(8'b1000_0000);
    check("abort_exec", int'(exec_dup), 0);
    check("abort_ocnt", int'(orig_cnt), 0);
    check("abort_qena", int'(qed_ena), 0);
    check("abort_err_kept", int'(qed_err), 1);

    // Reset in the middle of a drain.
    step(8'b0000_0000);
    step(8'b1100_0000);
    step(8'b1101_0000);
    step(8'b1100_0100);
    step(8'b1101_1000);
    check("pre_rst_drain", int'(fetch_hold), 1);
    step(8'b0100_0000);
    check("rst_drain_outs",
          int'({exec_dup, qed_ena, fetch_hold, qed_check, qed_err, orig_cnt}), 0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rin[7] = ($urandom_range(0, 299) != 0);
      rin[6] = ($urandom_range(0, 79) != 0);
      rin[5] = ($urandom_range(0, 3) == 0);
      rin[4] = 1'($urandom_range(0, 1));
      rin[3] = ($urandom_range(0, 15) != 0);
      rin[2] = ($urandom_range(0, 7) == 0);
      rin[1] = 1'($urandom_range(0, 1));
      rin[0] = 1'($urandom_range(0, 1));
      step(rin);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
